// File: rtl/lane_scan_sequencer.sv
// Latches a 6-bit word and steps a 2-bit lane mux across its three lanes.
// Define LANE_SCAN_BACK_TO_BACK_EN to accept the next word in the last scan cycle.
module lane_scan_sequencer #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] in_data,
    output logic       in_ready,
    input  logic       abort,
    output logic [5:0] x,
    output logic [1:0] sel,
    output logic       en,
    output logic       done
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t     state;
    logic [3:0] dwell;
    logic       dwell_end;
    logic       last;
    logic       accept;

    assign dwell_end = (dwell == 4'(DWELL - 1));
    assign last      = (state == SCAN) && (sel == 2'd2) && dwell_end;

`ifdef LANE_SCAN_BACK_TO_BACK_EN
    assign in_ready = rst_n && !abort && ((state == IDLE) || last);
`else
    assign in_ready = rst_n && !abort && (state == IDLE);
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            sel   <= '0;
            dwell <= '0;
            en    <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            // Cancel drops the scan silently; the latched word stays put.
            state <= IDLE;
            sel   <= '0;
            dwell <= '0;
            en    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x     <= in_data;
                        sel   <= '0;
                        dwell <= '0;
                        en    <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (dwell_end) begin
                        dwell <= '0;
                        if (sel == 2'd2) begin
                            done <= 1'b1;
                            sel  <= '0;
                            if (accept) begin
                                x  <= in_data;
                                en <= 1'b1;
                            end else begin
                                en    <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            sel <= sel + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
